vending_machine_multi_fsm: RTL
==============================

Name: vending_machine_multi_fsm

Overview:
Parametrised multi-product vending controller. Successor to the single-price 10 Taka vending FSM. Accumulates credit in 5 Taka units across cycles and sells N_PROD products, each with a runtime-programmable price. Tracks per-product stock, returns change serially as greedy coins, and supports cancel/refund. Sits between the coin acceptor front end and the dispenser/coin-hopper drivers.

Parameters:
N_PROD, 4, number of products (>=2)
SEL_W, 2, width of product index; must equal clog2(N_PROD)
UNIT_W, 5, credit/price width in 5 Taka units
MAX_CREDIT, 20, credit ceiling in units (100 Taka); must be < 2^UNIT_W
STOCK_W, 4, per-product stock counter width
STOCK_INIT, 8, stock loaded on reset/restock; must be < 2^STOCK_W

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
cash_in  in  2  coin this cycle: 00 none, 01 5Tk (1 unit), 10 10Tk (2), 11 20Tk (4)
cancel  in  1  refund request
sel_valid  in  1  product selection strobe
sel_idx  in  SEL_W  selected product
price_flat  in  N_PROD*UNIT_W  price of product i at bits [i*UNIT_W +: UNIT_W], units
restock  in  1  reload all stock counters
purchase  out  1  one-cycle dispense pulse
product_idx  out  SEL_W  product being dispensed; valid with purchase
cash_return  out  2  change coin this cycle: 00 none, 01 5Tk, 10 10Tk, 11 20Tk
coin_reject  out  1  coin from previous cycle bounced, credit unchanged
sel_error  out  1  one-cycle pulse, selection refused
credit  out  UNIT_W  current credit, units
stock_empty  out  N_PROD  bit i = stock of product i is 0
present_state  out  2  IDLE=00, CREDIT=01, VEND=10, CHANGE=11

Behaviour:
- All outputs registered. Reset: state IDLE, credit 0, all pulses/cash_return/product_idx 0, stock = STOCK_INIT, stock_empty 0. Reset mid-operation discards pending change with no refund; this is accepted.
- IDLE and CREDIT: a coin with credit+value <= MAX_CREDIT adds to credit next cycle; state becomes CREDIT. Otherwise coin_reject=1 next cycle.
- In VEND and CHANGE, any nonzero cash_in gives coin_reject=1.
- Priority in IDLE/CREDIT, same cycle: cancel > sel_valid > coin. A coin arriving with cancel or sel_valid is rejected.
- cancel in CREDIT: go to CHANGE. cancel in IDLE: ignored.
- sel_valid in IDLE/CREDIT: accepted iff price!=0, credit>=price, and stock>0. Accepted selection goes to VEND and latches the index. Refused selection gives sel_error=1 next cycle, with state and credit unchanged.
- VEND (1 cycle): purchase=1, product_idx=latched index. Credit -= price, stock[idx] -= 1. Next state is CHANGE if the remaining credit is >0, else IDLE.
- Latency: sel_valid at cycle t produces purchase at t+1, and the first change coin at t+2.
- CHANGE: one coin per cycle, greedy. credit>=4 gives 11 (-4), >=2 gives 10 (-2), else 01 (-1). Go to IDLE in the cycle the credit reaches 0. cancel and sel_valid are ignored.
- restock: any state, sets all stock to STOCK_INIT next cycle. It overrides a simultaneous VEND decrement.
- Stock never underflows; selection is refused at 0. stock_empty follows the counters with one-cycle latency.
- Credit arithmetic is in UNIT_W+1 bits before compare, so there is no wrap.

Test Plan:
- Prices p0=2, p1=3. Insert 01, 01, then sel 0: purchase=1, product_idx=0, cash_return 00, credit 0, back to IDLE.
- Insert 11, then sel 1: purchase at next cycle, then one cycle cash_return=01, then IDLE, credit 0.
- Insert 11 x5: credit=20. Sixth 11 gives coin_reject=1, credit stays 20. cancel gives cash_return=11 for 5 consecutive cycles, then IDLE.
- Insert 01, then sel 1: sel_error=1, credit stays 1, state CREDIT. Coin and sel_valid in the same cycle: coin_reject=1.
- STOCK_INIT=2: buy p0 twice, then stock_empty[0]=1. Third sel 0 with credit 2 gives sel_error. restock gives stock_empty[0]=0, and the sale succeeds.
- Insert 11 x2 (credit 8), sel 0 (price 2): change 11, 10, then IDLE. Assert reset during the 11 cycle: next cycle all outputs 0, credit 0, IDLE.

Source files
------------

// File: rtl/vending_machine_multi_fsm_if.sv
// vending_machine_multi_fsm_if: coin, selection and dispense signals between front end and controller
interface vending_machine_multi_fsm_if #(
    parameter int N_PROD = 4,
    parameter int SEL_W  = 2,
    parameter int UNIT_W = 5
);
    logic [1:0]               cash_in;
    logic                     cancel;
    logic                     sel_valid;
    logic [SEL_W-1:0]         sel_idx;
    logic [N_PROD*UNIT_W-1:0] price_flat;
    logic                     restock;
    logic                     purchase;
    logic [SEL_W-1:0]         product_idx;
    logic [1:0]               cash_return;
    logic                     coin_reject;
    logic                     sel_error;
    logic [UNIT_W-1:0]        credit;
    logic [N_PROD-1:0]        stock_empty;
    logic [1:0]               present_state;

    modport master (
        output cash_in, cancel, sel_valid, sel_idx, price_flat, restock,
        input  purchase, product_idx, cash_return, coin_reject, sel_error, credit, stock_empty, present_state
    );

    modport slave (
        input  cash_in, cancel, sel_valid, sel_idx, price_flat, restock,
        output purchase, product_idx, cash_return, coin_reject, sel_error, credit, stock_empty, present_state
    );
endinterface

// File: rtl/vending_machine_multi_fsm.sv
// vending_machine_multi_fsm: multi-product credit, vend and greedy change controller
module vending_machine_multi_fsm #(
    parameter int N_PROD     = 4,
    parameter int SEL_W      = 2,
    parameter int UNIT_W     = 5,
    parameter int MAX_CREDIT = 20,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8
) (
    input logic clock,
    input logic reset,
    vending_machine_multi_fsm_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, CREDIT = 2'b01, VEND = 2'b10, CHANGE = 2'b11} state_t;

    state_t              state, state_n;
    logic [UNIT_W-1:0]   credit, credit_n, price_sel, price_vend, chg_src, chg_val;
    logic [UNIT_W:0]     sum;
    logic [SEL_W-1:0]    prod, prod_n;
    logic [1:0]          cash_ret, cash_ret_n, coin;
    logic                purchase, purchase_n, coin_rej, coin_rej_n, sel_err, sel_err_n, sel_ok;
    logic [STOCK_W-1:0]  stock [N_PROD];
    logic [N_PROD-1:0]   empty;

    assign price_sel  = bus.price_flat[bus.sel_idx*UNIT_W +: UNIT_W];
    assign price_vend = bus.price_flat[prod*UNIT_W +: UNIT_W];
    assign sum        = {1'b0, credit} + (bus.cash_in == 2'b11 ? (UNIT_W+1)'(4) : (UNIT_W+1)'(bus.cash_in));
    assign sel_ok     = price_sel != '0 && credit >= price_sel && stock[bus.sel_idx] != '0;
    // In VEND the change source is the post-sale remainder, so the first coin leaves one cycle after purchase
    assign chg_src    = state == VEND ? credit - price_vend : credit;
    assign coin       = chg_src >= UNIT_W'(4) ? 2'b11 : chg_src >= UNIT_W'(2) ? 2'b10 : 2'b01;
    assign chg_val    = coin == 2'b11 ? UNIT_W'(4) : UNIT_W'(coin);

    assign bus.purchase      = purchase;
    assign bus.product_idx   = prod;
    assign bus.cash_return   = cash_ret;
    assign bus.coin_reject   = coin_rej;
    assign bus.sel_error     = sel_err;
    assign bus.credit        = credit;
    assign bus.stock_empty   = empty;
    assign bus.present_state = state;

    // Next state and next registered outputs; cancel beats selection beats coin
    always_comb begin
        state_n    = state;
        credit_n   = credit;
        prod_n     = '0;
        cash_ret_n = 2'b00;
        purchase_n = 1'b0;
        sel_err_n  = 1'b0;
        coin_rej_n = bus.cash_in != 2'b00;
        if (state == IDLE || state == CREDIT) begin
            if (bus.cancel) begin
                if (state == CREDIT) begin
                    state_n    = CHANGE;
                    cash_ret_n = coin;
                    credit_n   = chg_src - chg_val;
                end
            end else if (bus.sel_valid) begin
                state_n    = sel_ok ? VEND : state;
                prod_n     = sel_ok ? bus.sel_idx : '0;
                purchase_n = sel_ok;
                sel_err_n  = !sel_ok;
            end else if (sum <= (UNIT_W+1)'(MAX_CREDIT)) begin
                coin_rej_n = 1'b0;
                credit_n   = sum[UNIT_W-1:0];
                state_n    = bus.cash_in != 2'b00 ? CREDIT : state;
            end
        end else begin
            state_n    = chg_src == '0 ? IDLE : CHANGE;
            cash_ret_n = chg_src == '0 ? 2'b00 : coin;
            credit_n   = chg_src == '0 ? '0 : chg_src - chg_val;
        end
    end

    // State, credit and registered outputs; stock_empty trails the counters by one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            credit   <= '0;
            prod     <= '0;
            cash_ret <= 2'b00;
            purchase <= 1'b0;
            coin_rej <= 1'b0;
            sel_err  <= 1'b0;
            empty    <= '0;
        end else begin
            state    <= state_n;
            credit   <= credit_n;
            prod     <= prod_n;
            cash_ret <= cash_ret_n;
            purchase <= purchase_n;
            coin_rej <= coin_rej_n;
            sel_err  <= sel_err_n;
            for (int i = 0; i < N_PROD; i++) empty[i] <= stock[i] == '0;
        end
    end

    // Stock counters; restock wins over a same-cycle vend decrement
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_PROD; i++) begin
            if (reset || bus.restock) stock[i] <= STOCK_W'(STOCK_INIT);
            else if (state == VEND && prod == SEL_W'(i) && stock[i] != '0) stock[i] <= stock[i] - 1'b1;
        end
    end
endmodule
